regbank_exec_wb: RTL and testbench

- Two-stage execute/writeback pipeline sitting directly in front of regbank_v4.
- Drives regbank_v4 read addresses (sr1, sr2) and consumes rdData1/rdData2.
- Applies an ALU operation and drives the regbank_v4 write port (dr, wrData, write).
- Full forwarding from both of its own stages, so back-to-back dependent ops run with no bubbles.

---
 rtl/regbank_exec_wb.sv | 140 ++++++++++++++
 tb/tb_regbank_exec_wb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_exec_wb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regbank_exec_wb : two-stage execute/writeback pipeline in front of regbank_v4
//                   with full EX/WB operand forwarding and a writeback counter.
// Revision 1.0
// ----------------------------------------------------------------------------
module regbank_exec_wb #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_sr1,
  input  logic [AW-1:0]    in_sr2,
  input  logic [AW-1:0]    in_dr,
  input  logic             hold,
  output logic [AW-1:0]    sr1,
  output logic [AW-1:0]    sr2,
  input  logic [WIDTH-1:0] rdData1,
  input  logic [WIDTH-1:0] rdData2,
  output logic [AW-1:0]    dr,
  output logic [WIDTH-1:0] wrData,
  output logic             write,
  output logic [15:0]      retired
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  logic             ex_valid_q, ex_valid_d;
  logic [2:0]       ex_op_q, ex_op_d;
  logic [AW-1:0]    ex_dr_q, ex_dr_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d;
  logic [WIDTH-1:0] ex_b_q, ex_b_d;
  logic             wb_valid_q, wb_valid_d;
  logic [AW-1:0]    wb_dr_q, wb_dr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [15:0]      retired_q, retired_d;

  logic             accept;
  logic [WIDTH-1:0] ex_result;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  assign in_ready = ~reset & ~hold;
  assign accept   = in_valid & in_ready;
  assign sr1      = in_sr1;
  assign sr2      = in_sr2;
  assign dr       = wb_dr_q;
  assign wrData   = wb_data_q;
  // Gating with reset keeps a discarded WB entry from reaching the regbank.
  assign write    = wb_valid_q & ~hold & ~reset;
  assign retired  = retired_q;

  always_comb begin
    ex_result = '0;
    case (ex_op_q)
      OP_ADD:  ex_result = ex_a_q + ex_b_q;
      OP_SUB:  ex_result = ex_a_q - ex_b_q;
      OP_AND:  ex_result = ex_a_q & ex_b_q;
      OP_OR:   ex_result = ex_a_q | ex_b_q;
      OP_XOR:  ex_result = ex_a_q ^ ex_b_q;
      OP_SLT:  ex_result = {{(WIDTH-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
      OP_SLL:  ex_result = ex_a_q << ex_b_q[4:0];
      OP_SRL:  ex_result = ex_a_q >> ex_b_q[4:0];
      default: ex_result = '0;
    endcase
  end

  // EX is checked last so the younger producer wins on an address match.
  always_comb begin
    op_a = rdData1;
    if (wb_valid_q && (wb_dr_q == in_sr1)) op_a = wb_data_q;
    if (ex_valid_q && (ex_dr_q == in_sr1)) op_a = ex_result;
    op_b = rdData2;
    if (wb_valid_q && (wb_dr_q == in_sr2)) op_b = wb_data_q;
    if (ex_valid_q && (ex_dr_q == in_sr2)) op_b = ex_result;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_dr_d    = ex_dr_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    wb_valid_d = wb_valid_q;
    wb_dr_d    = wb_dr_q;
    wb_data_d  = wb_data_q;
    retired_d  = retired_q + 16'(write);
    if (!hold) begin
      ex_valid_d = accept;
      if (accept) begin
        ex_op_d = in_op;
        ex_dr_d = in_dr;
        ex_a_d  = op_a;
        ex_b_d  = op_b;
      end
      wb_valid_d = ex_valid_q;
      if (ex_valid_q) begin
        wb_dr_d   = ex_dr_q;
        wb_data_d = ex_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_dr_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_dr_q    <= '0;
      wb_data_q  <= '0;
      retired_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_dr_q    <= ex_dr_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      wb_valid_q <= wb_valid_d;
      wb_dr_q    <= wb_dr_d;
      wb_data_q  <= wb_data_d;
      retired_q  <= retired_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_exec_wb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regbank_exec_wb : bench for regbank_exec_wb with a regbank_v4 stand-in and
//                      an in-order architectural reference model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_regbank_exec_wb;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int NREG  = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [AW-1:0]    in_sr1 = '0;
  logic [AW-1:0]    in_sr2 = '0;
  logic [AW-1:0]    in_dr = '0;
  logic             hold = 1'b0;
  logic [AW-1:0]    sr1, sr2, dr;
  logic [WIDTH-1:0] rdData1, rdData2, wrData;
  logic             write;
  logic [15:0]      retired;

  logic             pl_en = 1'b0;
  logic [AW-1:0]    pl_addr = '0;
  logic [WIDTH-1:0] pl_data = '0;
  logic [WIDTH-1:0] mem [NREG];

  regbank_exec_wb #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .hold(hold), .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
    .dr(dr), .wrData(wrData), .write(write), .retired(retired)
  );

  always #5 clk = ~clk;

  // regbank_v4 stand-in: combinational reads, write captured at the edge.
  assign rdData1 = mem[sr1];
  assign rdData2 = mem[sr2];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (write) mem[dr] <= wrData;
  end

  // Reference model: results computed in program order at accept time.
  typedef struct {
    logic [AW-1:0]    dr;
    logic [WIDTH-1:0] data;
    int               age;
  } ent_t;
  ent_t        q[$];
  logic [15:0] ref_ret = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Latest program-order value: youngest uncommitted producer, else the regbank.
  function automatic logic [31:0] lookup(input logic [AW-1:0] r);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].dr == r) return q[i].data;
    return mem[r];
  endfunction

  // One clock: compare outputs mid-cycle, advance the model for the next edge.
  task automatic cycle();
    logic ew;
    ent_t n;
    @(negedge clk);
    ew = !reset && !hold && (q.size() > 0) && (q[0].age == 1);
    chk("in_ready", 32'(in_ready), 32'(!reset && !hold));
    chk("sr1", 32'(sr1), 32'(in_sr1));
    chk("sr2", 32'(sr2), 32'(in_sr2));
    chk("write", 32'(write), 32'(ew));
    chk("retired", 32'(retired), 32'(ref_ret));
    if (ew) begin
      chk("dr", 32'(dr), 32'(q[0].dr));
      chk("wrData", wrData, q[0].data);
    end
    if (reset) begin
      q.delete();
      ref_ret = '0;
    end else if (!hold) begin
      n.dr = in_dr;
      n.data = alu(in_op, lookup(in_sr1), lookup(in_sr2));
      n.age = 0;
      if (ew) begin
        void'(q.pop_front());
        ref_ret++;
      end
      foreach (q[i]) q[i].age++;
      if (in_valid) q.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cycle();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] s1,
                       input logic [AW-1:0] s2, input logic [AW-1:0] d);
    in_valid = 1'b1; in_op = op; in_sr1 = s1; in_sr2 = s2; in_dr = d;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] ret0;
    @(posedge clk);
    #1;
    for (int r = 0; r < NREG; r++) preload(AW'(r), $urandom());

    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    idle(5);

    preload(5'd1, 32'd10);
    preload(5'd2, 32'd20);
    issue(3'd0, 5'd1, 5'd2, 5'd3);
    cycle();
    chk("add_write", 32'(write), 32'd1);
    chk("add_dr", 32'(dr), 32'd3);
    chk("add_wrData", wrData, 32'd30);
    idle(3);
    chk("r3_readback", mem[3], 32'd30);

    issue(3'd0, 5'd1, 5'd2, 5'd3);
    issue(3'd1, 5'd3, 5'd1, 5'd4);
    idle(3);
    chk("ex_fwd_r4", mem[4], 32'd20);

    preload(5'd3, 32'd0);
    issue(3'd0, 5'd1, 5'd2, 5'd3);
    cycle();
    issue(3'd4, 5'd3, 5'd2, 5'd5);
    idle(3);
    chk("wb_fwd_r5", mem[5], 32'd10);

    preload(5'd10, 32'hFFFF_FFF0);
    preload(5'd11, 32'd4);
    for (int o = 0; o < 8; o++) issue(3'(o), 5'd10, 5'd11, 5'(12 + o));
    idle(3);
    chk("sub", mem[13], 32'hFFFF_FFEC);
    chk("and", mem[14], 32'h0000_0000);
    chk("or", mem[15], 32'hFFFF_FFF4);
    chk("slt", mem[17], 32'h0000_0001);
    chk("sll", mem[18], 32'hFFFF_FF00);
    chk("srl", mem[19], 32'h0FFF_FFFF);

    issue(3'd0, 5'd1, 5'd2, 5'd6);
    cycle();
    ret0 = retired;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_write", 32'(write), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      cycle();
    end
    hold = 1'b0;
    #1;
    chk("release_write", 32'(write), 32'd1);
    cycle();
    chk("release_once", 32'(write), 32'd0);
    chk("release_retired", 32'(retired), 32'(ret0 + 16'd1));
    idle(2);
    chk("hold_r6", mem[6], 32'd30);

    preload(5'd20, 32'h55);
    preload(5'd21, 32'h66);
    issue(3'd0, 5'd1, 5'd2, 5'd20);
    issue(3'd0, 5'd1, 5'd1, 5'd21);
    reset = 1'b1;
    #1;
    chk("midrst_write", 32'(write), 32'd0);
    cycle();
    reset = 1'b0;
    idle(4);
    chk("midrst_r20", mem[20], 32'h55);
    chk("midrst_r21", mem[21], 32'h66);
    chk("midrst_retired", 32'(retired), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      hold     = ($urandom_range(0, 6) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 3'($urandom_range(0, 7));
      in_sr1   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 5));
      in_sr2   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 5));
      in_dr    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 5));
      cycle();
    end
    reset = 1'b0; hold = 1'b0; in_valid = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
